// File: rtl/cache_pkg.sv
// Shared types and constants for the cache round-robin drain scheduler.
package cache_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_HDR0,
        ST_HDR1,
        ST_READ,
        ST_DRAIN
    } state_e;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam int         CNT_W         = 16;
    localparam int         ID_W          = 8;

    // Channel index increment with wrap at n-1 back to 0.
    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] v, input int n);
        if (int'(v) >= n - 1) return '0;
        return v + ID_W'(1);
    endfunction

endpackage

// File: rtl/cache_rr_scheduler_if.sv
// Framed byte-stream port (valid/ready) carrying burst data, last flag and channel id.
interface cache_rr_scheduler_if;
    import cache_pkg::*;

    logic [7:0]      m_data;
    logic            m_valid;
    logic            m_ready;
    logic            m_last;
    logic [ID_W-1:0] m_id;

    modport master (output m_data, m_valid, m_last, m_id, input m_ready);
    modport slave  (input m_data, m_valid, m_last, m_id, output m_ready);

endinterface

// File: rtl/cache_skid_buf.sv
// Two-entry {data,last} FIFO between the FIFO read capture and the stream port.
module cache_skid_buf (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       push_i,
    input  logic [7:0] data_i,
    input  logic       last_i,
    output logic       room_o,
    output logic [1:0] cnt_o,
    output logic       valid_o,
    output logic [7:0] data_o,
    output logic       last_o,
    input  logic       ready_i
);

    logic [8:0] mem_q [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] cnt_q;
    logic       pop;
    logic [8:0] head;

    assign valid_o = (cnt_q != 2'd0);
    assign room_o  = (cnt_q != 2'd2);
    assign cnt_o   = cnt_q;
    assign pop     = valid_o & ready_i;
    assign head    = mem_q[rd_ptr_q];
    // Head is gated so an empty buffer presents zeros on the port.
    assign data_o  = valid_o ? head[8:1] : 8'h00;
    assign last_o  = valid_o & head[0];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push_i) wr_ptr_q <= ~wr_ptr_q;
            if (pop)    rd_ptr_q <= ~rd_ptr_q;
            unique case ({push_i, pop})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= {data_i, last_i};
    end

endmodule

// File: rtl/cache_rr_scheduler.sv
// Round-robin drain scheduler: reads BURST_LEN-byte bursts from cache FIFOs into a framed stream.
// Optional CACHE_RR_SCHEDULER_STATS_EN adds burst and stall counters.
module cache_rr_scheduler
    import cache_pkg::*;
#(
    parameter int         SENSOR_NUM = 20,
    parameter int         BURST_LEN  = 256,
    parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEF
) (
    input  logic                        sys_clk_i,
    input  logic                        rst_n_i,
    input  logic                        enable_i,
    output logic [SENSOR_NUM-1:0]       rd_en_o,
    input  logic [SENSOR_NUM*8-1:0]     rd_dout_i,
    input  logic [SENSOR_NUM-1:0]       empty_i,
    input  logic [SENSOR_NUM*CNT_W-1:0] rd_data_count_i,
    cache_rr_scheduler_if.master        m_if,
`ifdef CACHE_RR_SCHEDULER_STATS_EN
    output logic [31:0]                 stat_burst_cnt_o,
    output logic [31:0]                 stat_stall_cnt_o,
`endif
    output logic                        busy_o
);

    localparam logic [CNT_W-1:0] BURST_C = CNT_W'(BURST_LEN);

    state_e          state_q;
    logic [ID_W-1:0] id_q;
    logic [ID_W-1:0] rr_ptr_q;
    logic [CNT_W-1:0] rd_cnt_q;
    logic            vld_p0_q;
    logic            last_p0_q;

    logic [SENSOR_NUM-1:0] eligible;
    logic [ID_W:0]         pick;
    logic [7:0]            sel_dout;
    logic                  sel_empty;
    logic                  skid_room, skid_valid, skid_last, pop;
    logic [1:0]            skid_cnt;
    logic [7:0]            skid_data;
    logic [2:0]            occ_eff;
    logic                  credit_ok, rd_go, rd_last, hdr_push, push, push_last;
    logic [7:0]            push_data;
    logic                  drain_done;

    // First eligible channel at or after ptr, wrapping; MSB of result flags a hit.
    function automatic logic [ID_W:0] rr_pick(input logic [SENSOR_NUM-1:0] elig,
                                              input logic [ID_W-1:0] ptr);
        logic [ID_W:0] res;
        int            best;
        int            d;
        res  = '0;
        best = SENSOR_NUM;
        for (int i = 0; i < SENSOR_NUM; i++) begin
            d = (i >= int'(ptr)) ? i - int'(ptr) : i + SENSOR_NUM - int'(ptr);
            if (elig[i] && d < best) begin
                best = d;
                res  = {1'b1, ID_W'(i)};
            end
        end
        return res;
    endfunction

    always_comb begin
        eligible  = '0;
        sel_dout  = 8'h00;
        sel_empty = 1'b1;
        for (int i = 0; i < SENSOR_NUM; i++) begin
            eligible[i] = rd_data_count_i[i*CNT_W +: CNT_W] >= BURST_C;
            if (id_q == ID_W'(i)) begin
                sel_dout  = rd_dout_i[i*8 +: 8];
                sel_empty = empty_i[i];
            end
        end
    end

    assign pick = rr_pick(eligible, rr_ptr_q);

    // A byte popped this cycle frees its slot before the next read's data can land,
    // so counting it keeps one read per cycle without ever overfilling the buffer.
    assign pop       = skid_valid & m_if.m_ready;
    assign occ_eff   = {1'b0, skid_cnt} + {2'b00, vld_p0_q} - {2'b00, pop};
    assign credit_ok = occ_eff < 3'd2;
    assign rd_go     = (state_q == ST_READ) && credit_ok && !sel_empty;
    assign rd_last   = (rd_cnt_q == BURST_C - CNT_W'(1));
    assign hdr_push  = ((state_q == ST_HDR0) || (state_q == ST_HDR1)) && skid_room;

    always_comb begin
        rd_en_o = '0;
        for (int i = 0; i < SENSOR_NUM; i++) begin
            if (rd_go && id_q == ID_W'(i)) rd_en_o[i] = 1'b1;
        end
    end

    // Stage p0: FIFO output byte arrives one cycle after rd_en and is written into the skid.
    assign push      = vld_p0_q | hdr_push;
    assign push_last = vld_p0_q & last_p0_q;
    assign push_data = vld_p0_q ? sel_dout : ((state_q == ST_HDR0) ? SYNC_BYTE : id_q);

    cache_skid_buf u_skid (
        .clk_i   (sys_clk_i),
        .rst_n_i (rst_n_i),
        .push_i  (push),
        .data_i  (push_data),
        .last_i  (push_last),
        .room_o  (skid_room),
        .cnt_o   (skid_cnt),
        .valid_o (skid_valid),
        .data_o  (skid_data),
        .last_o  (skid_last),
        .ready_i (m_if.m_ready)
    );

    assign drain_done = (state_q == ST_DRAIN) && pop && skid_last;

    always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_IDLE;
            id_q      <= '0;
            rr_ptr_q  <= '0;
            rd_cnt_q  <= '0;
            vld_p0_q  <= 1'b0;
            last_p0_q <= 1'b0;
        end else begin
            vld_p0_q  <= rd_go;
            last_p0_q <= rd_go & rd_last;
            unique case (state_q)
                ST_IDLE: if (enable_i) state_q <= ST_SCAN;
                ST_SCAN: begin
                    if (!enable_i) begin
                        state_q <= ST_IDLE;
                    end else if (pick[ID_W]) begin
                        id_q     <= pick[ID_W-1:0];
                        rd_cnt_q <= '0;
                        state_q  <= ST_HDR0;
                    end
                end
                ST_HDR0: if (hdr_push) state_q <= ST_HDR1;
                ST_HDR1: if (hdr_push) state_q <= ST_READ;
                ST_READ: begin
                    if (rd_go) begin
                        rd_cnt_q <= rd_cnt_q + CNT_W'(1);
                        if (rd_last) state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (drain_done) begin
                        rr_ptr_q <= wrap_inc(id_q, SENSOR_NUM);
                        state_q  <= enable_i ? ST_SCAN : ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef CACHE_RR_SCHEDULER_STATS_EN
    logic [31:0] burst_cnt_q;
    logic [31:0] stall_cnt_q;

    always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            burst_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (drain_done)                   burst_cnt_q <= burst_cnt_q + 32'd1;
            if (skid_valid && !m_if.m_ready) stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stat_burst_cnt_o = burst_cnt_q;
    assign stat_stall_cnt_o = stall_cnt_q;
`endif

    assign m_if.m_data  = skid_data;
    assign m_if.m_valid = skid_valid;
    assign m_if.m_last  = skid_last;
    assign m_if.m_id    = id_q;
    assign busy_o       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cache_rr_scheduler.sv
// Scoreboard bench for cache_rr_scheduler with a behavioural FIFO bank model.
module tb_cache_rr_scheduler;

    localparam int N  = 20;
    localparam int BL = 256;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
        logic [7:0] id;
    } beat_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             enable;
    logic [N-1:0]     rd_en;
    logic [N-1:0]     empty;
    logic [N*8-1:0]   rd_dout = '0;
    logic [N*16-1:0]  cnt;
    logic             busy;
`ifdef CACHE_RR_SCHEDULER_STATS_EN
    logic [31:0]      stat_burst;
    logic [31:0]      stat_stall;
`endif

    int    wr_tot [N];
    int    rd_idx [N] = '{default: 0};
    int    exp_rd [N];
    beat_t exp_q [$];
    int    checks   = 0;
    int    failures = 0;
    bit    rnd_rdy  = 1'b0;

    cache_rr_scheduler_if mif();

    cache_rr_scheduler #(.SENSOR_NUM(N), .BURST_LEN(BL)) dut (
        .sys_clk_i       (clk),
        .rst_n_i         (rst_n),
        .enable_i        (enable),
        .rd_en_o         (rd_en),
        .rd_dout_i       (rd_dout),
        .empty_i         (empty),
        .rd_data_count_i (cnt),
        .m_if            (mif),
`ifdef CACHE_RR_SCHEDULER_STATS_EN
        .stat_burst_cnt_o(stat_burst),
        .stat_stall_cnt_o(stat_stall),
`endif
        .busy_o          (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pat(input int ch, input int idx);
        return 8'(ch * 37 + idx * 5 + idx / 256);
    endfunction

    // FIFO bank: data valid the cycle after rd_en, count = written - read.
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (rd_en[i]) begin
                rd_dout[i*8 +: 8] <= pat(i, rd_idx[i]);
                rd_idx[i]         <= rd_idx[i] + 1;
            end
        end
    end

    always_comb begin
        cnt   = '0;
        empty = '0;
        for (int i = 0; i < N; i++) begin
            cnt[i*16 +: 16] = 16'(wr_tot[i] - rd_idx[i]);
            empty[i]        = (wr_tot[i] == rd_idx[i]);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        if (rnd_rdy) mif.m_ready = ($urandom_range(0, 99) < 30);
    endtask

    task automatic add(input int ch, input int n);
        wr_tot[ch] += n;
    endtask

    task automatic push_frame(input int ch);
        beat_t b;
        b = '{d: 8'hA5, l: 1'b0, id: 8'(ch)};
        exp_q.push_back(b);
        b = '{d: 8'(ch), l: 1'b0, id: 8'(ch)};
        exp_q.push_back(b);
        for (int j = 0; j < BL; j++) begin
            b = '{d: pat(ch, exp_rd[ch] + j), l: (j == BL - 1), id: 8'(ch)};
            exp_q.push_back(b);
        end
        exp_rd[ch] += BL;
    endtask

    task automatic wait_size(input int n, input int max, input string tag);
        int k = 0;
        while (exp_q.size() > n && k < max) begin
            cyc();
            k++;
        end
        check_eq(tag, 32'(exp_q.size() > n), 0);
    endtask

    task automatic monitor();
        logic [N-1:0] gm;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (mif.m_valid) begin
                    if (exp_q.size() == 0) begin
                        check_eq("unexpected_beat", 1, 0);
                    end else begin
                        check_eq("data", 32'(mif.m_data), 32'(exp_q[0].d));
                        check_eq("last", 32'(mif.m_last), 32'(exp_q[0].l));
                        check_eq("id",   32'(mif.m_id),   32'(exp_q[0].id));
                        if (mif.m_ready) void'(exp_q.pop_front());
                    end
                end
                if (rd_en != '0) begin
                    gm = (exp_q.size() > 0) ? (N'(1) << exp_q[0].id) : '0;
                    check_eq("rden_grant", 32'(rd_en & ~gm), 0);
                    check_eq("rden_empty", 32'(rd_en & empty), 0);
                end
            end
        end
    endtask

    task automatic main_seq();
        int base;
        bit got;
        rst_n = 1'b0;
        enable = 1'b0;
        mif.m_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            wr_tot[i] = 0;
            exp_rd[i] = 0;
        end
        repeat (3) cyc();
        check_eq("rst_busy",  32'(busy), 0);
        check_eq("rst_valid", 32'(mif.m_valid), 0);
        check_eq("rst_rden",  32'(rd_en), 0);
        check_eq("rst_id",    32'(mif.m_id), 0);
        rst_n = 1'b1;
        cyc();
        check_eq("idle_busy", 32'(busy), 0);

        // single channel burst
        add(3, BL);
        push_frame(3);
        enable = 1'b1;
        wait_size(0, 2000, "t1_drain_timeout");
        check_eq("t1_reads", 32'(rd_idx[3]), 256);
        enable = 1'b0;
        repeat (3) cyc();
        check_eq("t1_busy_drop", 32'(busy), 0);

        // round robin from rr_ptr=0 over ch0/ch19, ch0 refilled
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        add(0, 2 * BL);
        add(19, BL);
        push_frame(0);
        push_frame(19);
        push_frame(0);
        enable = 1'b1;
        wait_size(0, 4000, "t2_drain_timeout");
`ifdef CACHE_RR_SCHEDULER_STATS_EN
        cyc();
        check_eq("t2_stat_bursts", stat_burst, 3);
`endif

        // threshold: 255 bytes is not eligible
        add(5, BL - 1);
        repeat (20) cyc();
        check_eq("t3_no_read", 32'(rd_idx[5]), 0);
        check_eq("t3_busy_scan", 32'(busy), 1);
        check_eq("t3_no_valid", 32'(mif.m_valid), 0);
        add(5, 1);
        push_frame(5);
        got = 1'b0;
        for (int k = 0; k < 3 && !got; k++) begin
            cyc();
            got = mif.m_valid;
        end
        check_eq("t3_start", 32'(got), 1);
        wait_size(0, 2000, "t3_drain_timeout");

        // random backpressure
        add(7, BL);
        base = rd_idx[7];
        push_frame(7);
        rnd_rdy = 1'b1;
        wait_size(0, 6000, "t4_drain_timeout");
        rnd_rdy = 1'b0;
        mif.m_ready = 1'b1;
        check_eq("t4_reads", 32'(rd_idx[7] - base), 256);

        // enable dropped after payload byte 10
        add(9, BL);
        push_frame(9);
        wait_size(BL + 2 - 12, 2000, "t5_mid_timeout");
        enable = 1'b0;
        add(11, BL);
        base = rd_idx[11];
        wait_size(0, 2000, "t5_drain_timeout");
        repeat (5) cyc();
        check_eq("t5_idle", 32'(busy), 0);
        check_eq("t5_no_grant", 32'(rd_idx[11] - base), 0);
        check_eq("t5_no_valid", 32'(mif.m_valid), 0);

        // reset mid-READ, then fresh scan from rr_ptr=0
        push_frame(11);
        enable = 1'b1;
        wait_size(BL + 2 - 50, 2000, "t6_mid_timeout");
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_valid", 32'(mif.m_valid), 0);
        check_eq("t6_rst_rden",  32'(rd_en), 0);
        check_eq("t6_rst_busy",  32'(busy), 0);
        check_eq("t6_rst_last",  32'(mif.m_last), 0);
        exp_q.delete();
        repeat (2) cyc();
        exp_rd[11] = rd_idx[11];
        add(2, BL);
        add(11, BL);
        push_frame(2);
        push_frame(11);
        rst_n = 1'b1;
        wait_size(0, 3000, "t6_drain_timeout");
        check_eq("t6_reads_ch2", 32'(rd_idx[2]), 256);
    endtask

    initial begin
        fork
            monitor();
            main_seq();
        join_any
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
